asym_bram_fifo_ctrl: RTL

//  Single-clock FIFO that packs a 9-bit input stream into an 18-bit output stream through one RAM_18K_BLK in SDP mode.
//  The block owns both RAM ports: it writes 9x2048 and reads 18x1024.

---
 rtl/asym_fifo_pkg.sv | 19 +
 rtl/asym_bram_fifo_ctrl_if.sv | 21 ++
 rtl/asym_bram_fifo_ctrl_bram.sv | 30 +++
 rtl/asym_bram_fifo_ctrl.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/asym_fifo_pkg.sv
// Shared types and constants for the 9-bit to 18-bit packing FIFO built on one RAM_18K_BLK.
package asym_fifo_pkg;

  localparam int NARROW_DEPTH = 2048;
  localparam int WIDE_DEPTH   = 1024;

  typedef logic [11:0] wr_ptr_t;
  typedef logic [10:0] rd_ptr_t;
  typedef logic [11:0] occ_t;

  localparam bit   LOW_HALF_FIRST = 1'b1;
  localparam occ_t OCC_FULL       = occ_t'(NARROW_DEPTH);

  // Narrow-entry occupancy; the read pointer counts wide words, so it is doubled.
  function automatic occ_t calcOcc(input wr_ptr_t wrPtr, input rd_ptr_t rdPtr);
    return wrPtr - {rdPtr, 1'b0};
  endfunction

endpackage

// File: rtl/asym_bram_fifo_ctrl_if.sv
// Stream handshake bundle for asym_bram_fifo_ctrl: narrow S side in, wide M side out.
interface asym_bram_fifo_ctrl_if;

  logic        S_VALID_i;
  logic        S_READY_o;
  logic [8:0]  S_DATA_i;
  logic        M_VALID_o;
  logic        M_READY_i;
  logic [17:0] M_DATA_o;

  modport slave (
    input  S_VALID_i, S_DATA_i, M_READY_i,
    output S_READY_o, M_VALID_o, M_DATA_o
  );

  modport master (
    output S_VALID_i, S_DATA_i, M_READY_i,
    input  S_READY_o, M_VALID_o, M_DATA_o
  );

endinterface

// File: rtl/asym_bram_fifo_ctrl_bram.sv
// Behavioural RAM_18K_BLK in simple dual-port mode: 9-bit writes, 18-bit reads, 1-clock read latency.
module RAM_18K_BLK #(
  parameter int WR_ADDR_WIDTH = 11,
  parameter int RD_ADDR_WIDTH = 10,
  parameter int WR_DATA_WIDTH = 9,
  parameter int RD_DATA_WIDTH = 18
) (
  input  logic                     WR_CLK_i,
  input  logic                     RD_CLK_i,
  input  logic                     WEN_i,
  input  logic                     WR_BE_i,
  input  logic [WR_ADDR_WIDTH-1:0] WR_ADDR_i,
  input  logic [WR_DATA_WIDTH-1:0] WR_DATA_i,
  input  logic                     REN_i,
  input  logic [RD_ADDR_WIDTH-1:0] RD_ADDR_i,
  output logic [RD_DATA_WIDTH-1:0] RDATA_o
);

  logic [WR_DATA_WIDTH-1:0] mem [0:(1<<WR_ADDR_WIDTH)-1];

  always_ff @(posedge WR_CLK_i) begin
    if (WEN_i && WR_BE_i) mem[WR_ADDR_i] <= WR_DATA_i;
  end

  // Even narrow entry lands in the low half of the wide word.
  always_ff @(posedge RD_CLK_i) begin
    if (REN_i) RDATA_o <= {mem[{RD_ADDR_i, 1'b1}], mem[{RD_ADDR_i, 1'b0}]};
  end

endmodule

// File: rtl/asym_bram_fifo_ctrl.sv
// Single-clock 9-to-18 bit packing FIFO controller driving one RAM_18K_BLK plus a 2-entry output buffer.
// Optional ALMOST_FULL_o/ALMOST_EMPTY_o flags are built only when ASYM_FIFO_ALMOST_EN is defined.
module asym_bram_fifo_ctrl
  import asym_fifo_pkg::*;
#(
  parameter int WR_ADDR_WIDTH = $clog2(NARROW_DEPTH),
  parameter int RD_ADDR_WIDTH = $clog2(WIDE_DEPTH),
  parameter int WR_DATA_WIDTH = 9,
  parameter int RD_DATA_WIDTH = 18
`ifdef ASYM_FIFO_ALMOST_EN
  ,
  parameter int AF_MARGIN     = 16,
  parameter int AE_MARGIN     = 2
`endif
) (
  input  logic                  clock0,
  input  logic                  RESET_i,
  asym_bram_fifo_ctrl_if.slave  bus
`ifdef ASYM_FIFO_ALMOST_EN
  ,
  output logic                  ALMOST_FULL_o,
  output logic                  ALMOST_EMPTY_o
`endif
);

  wr_ptr_t wrPtr_q, wrPtr_d;
  rd_ptr_t rdPtr_q, rdPtr_d;
  occ_t    occCur, occ_d;
  logic    sReady_q, sReady_d;
  logic    inFlight_q;
  logic [1:0] bufCnt_q, bufCnt_d;
  logic [RD_DATA_WIDTH-1:0] head_q, head_d, tail_q, tail_d;
  logic [RD_DATA_WIDTH-1:0] ramRdata, rdWord;
  logic    accept, pop, issue;

  RAM_18K_BLK #(
    .WR_ADDR_WIDTH(WR_ADDR_WIDTH),
    .RD_ADDR_WIDTH(RD_ADDR_WIDTH),
    .WR_DATA_WIDTH(WR_DATA_WIDTH),
    .RD_DATA_WIDTH(RD_DATA_WIDTH)
  ) u_bram (
    .WR_CLK_i (clock0),
    .RD_CLK_i (clock0),
    .WEN_i    (accept),
    .WR_BE_i  (1'b1),
    .WR_ADDR_i(wrPtr_q[WR_ADDR_WIDTH-1:0]),
    .WR_DATA_i(bus.S_DATA_i),
    .REN_i    (issue),
    .RD_ADDR_i(rdPtr_q[RD_ADDR_WIDTH-1:0]),
    .RDATA_o  (ramRdata)
  );

  assign rdWord = LOW_HALF_FIRST ? ramRdata
                                 : {ramRdata[WR_DATA_WIDTH-1:0], ramRdata[RD_DATA_WIDTH-1:WR_DATA_WIDTH]};

  // Issue uses occupancy from registered pointers, so a beat is never read back in the cycle it is written.
  always_comb begin
    accept   = bus.S_VALID_i && sReady_q;
    pop      = (bufCnt_q != 2'd0) && bus.M_READY_i;
    occCur   = calcOcc(wrPtr_q, rdPtr_q);
    issue    = (occCur >= occ_t'(2)) &&
               (({1'b0, bufCnt_q} + {2'b0, inFlight_q}) < (3'd2 + {2'b0, pop}));
    wrPtr_d  = wrPtr_q + wr_ptr_t'(accept);
    rdPtr_d  = rdPtr_q + rd_ptr_t'(issue);
    occ_d    = calcOcc(wrPtr_d, rdPtr_d);
    sReady_d = (occ_d != OCC_FULL);
  end

  // Returning RAM words enter the 2-entry buffer; the head register drives the M side directly.
  always_comb begin
    head_d   = head_q;
    tail_d   = tail_q;
    bufCnt_d = bufCnt_q;
    case ({inFlight_q, pop})
      2'b10: begin
        if (bufCnt_q == 2'd0) head_d = rdWord;
        else                  tail_d = rdWord;
        bufCnt_d = bufCnt_q + 2'd1;
      end
      2'b01: begin
        head_d   = tail_q;
        bufCnt_d = bufCnt_q - 2'd1;
      end
      2'b11: begin
        if (bufCnt_q == 2'd1) begin
          head_d = rdWord;
        end else begin
          head_d = tail_q;
          tail_d = rdWord;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock0 or posedge RESET_i) begin
    if (RESET_i) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      sReady_q   <= 1'b1;
      inFlight_q <= 1'b0;
      bufCnt_q   <= 2'd0;
      head_q     <= '0;
      tail_q     <= '0;
    end else begin
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      sReady_q   <= sReady_d;
      inFlight_q <= issue;
      bufCnt_q   <= bufCnt_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
    end
  end

  assign bus.S_READY_o = sReady_q;
  assign bus.M_VALID_o = (bufCnt_q != 2'd0);
  assign bus.M_DATA_o  = head_q;

`ifdef ASYM_FIFO_ALMOST_EN
  logic almostFull_q, almostEmpty_q;
  logic [11:0] wideWords_d;

  // Words still in the RAM plus those buffered or on their way back from the read port.
  assign wideWords_d = {1'b0, occ_d[11:1]} + {10'b0, bufCnt_d} + {11'b0, issue};

  always_ff @(posedge clock0 or posedge RESET_i) begin
    if (RESET_i) begin
      almostFull_q  <= 1'b0;
      almostEmpty_q <= 1'b1;
    end else begin
      almostFull_q  <= (occ_d >= occ_t'(NARROW_DEPTH - AF_MARGIN));
      almostEmpty_q <= (wideWords_d <= 12'(AE_MARGIN));
    end
  end

  assign ALMOST_FULL_o  = almostFull_q;
  assign ALMOST_EMPTY_o = almostEmpty_q;
`endif

endmodule
